// File: rtl/exibe_sequencia_ctrl.sv
// exibe_sequencia_ctrl: steps a display through sequence addresses 0..ultimo, then blinks all LEDs N_PISCA times.
// Ports:
//   clock    - single clock, rising edge
//   reset    - asynchronous active-low reset
//   iniciar  - start a display run (ignored while ocupado)
//   abortar  - cancel the current run, back to idle without pronto
//   ultimo   - last address of the sequence, latched at start
//   endereco - address currently shown
//   led_on   - show memory data at endereco
//   pisca    - light all LEDs during the end blink phase
//   ocupado  - run in progress
//   pronto   - one-cycle pulse on normal completion
module exibe_sequencia_ctrl #(
  parameter int T_ON    = 4,
  parameter int T_OFF   = 2,
  parameter int N_PISCA = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       abortar,
  input  logic [3:0] ultimo,
  output logic [3:0] endereco,
  output logic       led_on,
  output logic       pisca,
  output logic       ocupado,
  output logic       pronto
);
  localparam int TMAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int CW   = (N_PISCA > 1) ? $clog2(N_PISCA) : 1;
  localparam logic [TW-1:0] ON_LAST  = TW'(T_ON - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(T_OFF - 1);
  // With N_PISCA=0 the blink states are unreachable, so the clamp only keeps the constant legal.
  localparam logic [CW-1:0] C_LAST   = CW'((N_PISCA > 0) ? N_PISCA - 1 : 0);

  typedef enum logic [2:0] {OCIOSO, ACENDE, APAGA, PISCA_ON, PISCA_OFF, FIM} state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    ult, ult_n;
  logic [3:0]    end_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= OCIOSO;
      timer    <= '0;
      cnt      <= '0;
      ult      <= '0;
      endereco <= '0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      cnt      <= cnt_n;
      ult      <= ult_n;
      endereco <= end_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    cnt_n   = cnt;
    ult_n   = ult;
    end_n   = endereco;
    if (abortar && state != OCIOSO) begin
      // Abort outranks any timer expiry; endereco is left as-is for inspection.
      state_n = OCIOSO;
      timer_n = '0;
    end else begin
      case (state)
        OCIOSO:
          if (iniciar && !abortar) begin
            state_n = ACENDE;
            ult_n   = ultimo;
            end_n   = '0;
            timer_n = '0;
          end
        ACENDE:
          if (timer == ON_LAST) begin
            state_n = APAGA;
            timer_n = '0;
          end else timer_n = timer + 1'b1;
        APAGA:
          if (timer == OFF_LAST) begin
            timer_n = '0;
            if (endereco == ult) begin
              state_n = (N_PISCA == 0) ? FIM : PISCA_ON;
              cnt_n   = '0;
            end else begin
              state_n = ACENDE;
              end_n   = endereco + 4'd1;
            end
          end else timer_n = timer + 1'b1;
        PISCA_ON:
          if (timer == ON_LAST) begin
            state_n = PISCA_OFF;
            timer_n = '0;
          end else timer_n = timer + 1'b1;
        PISCA_OFF:
          if (timer == OFF_LAST) begin
            timer_n = '0;
            state_n = (cnt == C_LAST) ? FIM : PISCA_ON;
            cnt_n   = (cnt == C_LAST) ? cnt : cnt + 1'b1;
          end else timer_n = timer + 1'b1;
        FIM:     state_n = OCIOSO;
        default: state_n = OCIOSO;
      endcase
    end
  end

  assign led_on  = state == ACENDE;
  assign pisca   = state == PISCA_ON;
  assign ocupado = state != OCIOSO;
  assign pronto  = state == FIM;
endmodule

// File: tb/tb_exibe_sequencia_ctrl.sv
// tb_exibe_sequencia_ctrl: directed self-checking bench for exibe_sequencia_ctrl with default parameters.
module tb_exibe_sequencia_ctrl;
  localparam int T_ON = 4, T_OFF = 2, N_P = 3, PER = T_ON + T_OFF;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       abortar = 1'b0;
  logic [3:0] ultimo = 4'd0;
  logic [3:0] endereco;
  logic       led_on, pisca, ocupado, pronto;
  int         errors = 0;
  int         checks = 0;

  exibe_sequencia_ctrl #(.T_ON(T_ON), .T_OFF(T_OFF), .N_PISCA(N_P)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .abortar(abortar), .ultimo(ultimo),
    .endereco(endereco), .led_on(led_on), .pisca(pisca), .ocupado(ocupado), .pronto(pronto)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] obs();
    return {endereco, led_on, pisca, ocupado, pronto};
  endfunction

  // Expected {endereco, led_on, pisca, ocupado, pronto} at cycle k (k=1 is the first cycle after the start edge).
  function automatic logic [7:0] exp_vec(input int k, input logic [3:0] u, input int len);
    int p, w;
    logic on;
    logic [3:0] pa;
    if (k == len) return {u, 4'b0011};
    p  = (k - 1) / PER;
    w  = (k - 1) % PER;
    on = w < T_ON;
    pa = p[3:0];
    if (p <= int'(u)) return {pa, on, 1'b0, 1'b1, 1'b0};
    return {u, 1'b0, on, 1'b1, 1'b0};
  endfunction

  task automatic chk(input string tag, input int k, input logic [7:0] o, input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b (endereco,led_on,pisca,ocupado,pronto)", tag, k, o, e);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs one display; optionally aborts after cycle abort_k, or pulses iniciar and changes ultimo at cycle inic_k.
  task automatic run(input string tag, input logic [3:0] u, input int abort_k, input int inic_k, input logic [3:0] u2);
    int len;
    bit done;
    len = (int'(u) + 1 + N_P) * PER + 1;
    done = 0;
    ultimo = u;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    for (int k = 1; k <= len && !done; k++) begin
      chk(tag, k, obs(), exp_vec(k, u, len));
      if (k == abort_k) begin
        abortar = 1'b1;
        step();
        abortar = 1'b0;
        chk({tag, "_abort"}, k + 1, obs(), {u, 4'b0000});
        for (int j = 0; j < 8; j++) begin
          step();
          chk({tag, "_abort_idle"}, k + 2 + j, obs(), {u, 4'b0000});
        end
        done = 1;
      end else begin
        iniciar = (k == inic_k);
        if (k == inic_k) ultimo = u2;
        step();
      end
    end
    iniciar = 1'b0;
    if (!done) begin
      chk({tag, "_after"}, len + 1, obs(), {u, 4'b0000});
      step();
      chk({tag, "_hold"}, len + 2, obs(), {u, 4'b0000});
    end
  endtask

  initial begin
    #1;
    chk("reset", 0, obs(), 8'h00);
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle", i, obs(), 8'h00);
    end
    run("u2", 4'd2, -1, -1, 4'd0);
    run("u0", 4'd0, -1, -1, 4'd0);
    run("u15", 4'd15, -1, -1, 4'd0);
    // Cycles 29-30 are the second PISCA_OFF for ultimo=2.
    run("abort", 4'd2, 29, -1, 4'd0);
    run("reinit", 4'd2, -1, 5, 4'd7);
    ultimo = 4'd5;
    iniciar = 1'b1;
    abortar = 1'b1;
    step();
    iniciar = 1'b0;
    abortar = 1'b0;
    chk("both", 0, obs(), {4'd2, 4'b0000});
    step();
    chk("both_idle", 1, obs(), {4'd2, 4'b0000});
    ultimo = 4'd2;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("pre_reset", 8, obs(), {4'd1, 4'b1010});
    #2 reset = 1'b0;
    #1 chk("async_reset", 8, obs(), 8'h00);
    #2 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_reset_idle", i, obs(), 8'h00);
    end
    run("after_reset", 4'd1, -1, -1, 4'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/exibe_sequencia_ctrl.md
EXIBE_SEQUENCIA_CTRL -- requirements
Module: exibe_sequencia_ctrl

Interface
REQ-001 The block SHALL have parameter T_ON, default 4, giving the number of cycles the LED or blink is on per step (minimum 1).
REQ-002 The block SHALL have parameter T_OFF, default 2, giving the number of cycles the LED or blink is off per step (minimum 1).
REQ-003 The block SHALL have parameter N_PISCA, default 3, giving the number of end-of-display blinks (0 allowed).
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port iniciar, input, 1 bit: start request for a display run.
REQ-007 The block SHALL have port abortar, input, 1 bit: cancel the current run.
REQ-008 The block SHALL have port ultimo, input, 4 bits: last sequence address to display (sequence length = ultimo+1).
REQ-009 The block SHALL have port endereco, output, 4 bits: sequence memory address currently shown.
REQ-010 The block SHALL have port led_on, output, 1 bit: enables the datapath LEDs to show memory data at endereco.
REQ-011 The block SHALL have port pisca, output, 1 bit: lights all LEDs during the end blink phase.
REQ-012 The block SHALL have port ocupado, output, 1 bit: high whenever the state is not OCIOSO.
REQ-013 The block SHALL have port pronto, output, 1 bit: one-cycle pulse on normal completion.

Function
REQ-014 The block SHALL implement a Moore FSM with states OCIOSO, ACENDE, APAGA, PISCA_ON, PISCA_OFF and FIM; all outputs decode from registered state and counters only.
REQ-015 In OCIOSO, when iniciar=1 and abortar=0, the block SHALL latch ultimo, clear endereco and the timer, and enter ACENDE on the next edge.
REQ-016 In ACENDE, led_on SHALL be 1 for exactly T_ON cycles (timer counts 0..T_ON-1), after which the block SHALL enter APAGA with the timer cleared.
REQ-017 In APAGA, led_on SHALL be 0 for exactly T_OFF cycles; at expiry, if endereco equals the latched ultimo the block SHALL enter PISCA_ON (or FIM if N_PISCA=0) with the blink count cleared, otherwise endereco SHALL increment by 1 and the block SHALL enter ACENDE.
REQ-018 endereco SHALL never wrap; with latched ultimo=15 it SHALL stop at 15.
REQ-019 In PISCA_ON, pisca SHALL be 1 for T_ON cycles, and then the block SHALL enter PISCA_OFF.
REQ-020 In PISCA_OFF, pisca SHALL be 0 for T_OFF cycles; at expiry, if the blink count equals N_PISCA-1 the block SHALL enter FIM, otherwise it SHALL increment the count and enter PISCA_ON.
REQ-021 In FIM, pronto SHALL be 1 for exactly one cycle, and then the block SHALL enter OCIOSO.
REQ-022 Total run length from the iniciar edge to pronto SHALL be (ultimo+1+N_PISCA)*(T_ON+T_OFF)+1 cycles, with pronto in the last of these cycles.
REQ-023 abortar=1 in any state other than OCIOSO SHALL force OCIOSO on the next edge, with priority over timer expiry and without asserting pronto.
REQ-024 iniciar while ocupado=1 SHALL be ignored.
REQ-025 When iniciar=1 and abortar=1 occur together in OCIOSO, the block SHALL remain in OCIOSO.
REQ-026 Changes on ultimo after the latch SHALL have no effect until the next run.
REQ-027 endereco SHALL hold its last value in OCIOSO after pronto or an abort, until the next iniciar.
REQ-028 The timer SHALL be sized for max(T_ON, T_OFF) and the blink counter for N_PISCA, with no overflow for any legal parameter value.

Reset
REQ-029 reset=0 SHALL immediately, without waiting for a clock edge, force state OCIOSO, endereco=0, led_on=0, pisca=0, ocupado=0, pronto=0, and clear the timer, blink count and latched ultimo.
REQ-030 reset deassertion SHALL leave the block in OCIOSO awaiting iniciar, including when reset was asserted in the middle of a run.

Verification
REQ-031 The bench SHALL cover: ultimo=2, 1-cycle iniciar -> led_on high 4 cycles then low 2 at endereco 0, 1, 2; then 3 pisca pulses of 4 on / 2 off; pronto on cycle 37 after iniciar, then ocupado=0.
REQ-032 The bench SHALL cover: ultimo=0 -> a single led_on pulse at endereco 0, 3 pisca pulses, pronto on cycle 25.
REQ-033 The bench SHALL cover: ultimo=15 -> endereco steps 0..15 with no wrap; pronto on cycle 115; endereco=15 afterwards.
REQ-034 The bench SHALL cover: abortar during the second PISCA_OFF -> OCIOSO next cycle, pronto never asserted, pisca=0.
REQ-035 The bench SHALL cover: iniciar pulsed at cycle 5 of a run and ultimo changed from 2 to 7 mid-run -> run unaffected, pronto still on cycle 37.
REQ-036 The bench SHALL cover: reset=0 asserted between clock edges during ACENDE -> led_on, ocupado and endereco go to 0 before the next edge; after release, outputs stay idle until iniciar.
